// File: rtl/lock_arbiter_if.sv
// lock_arbiter_if: REQ/GNT bundle between two requester units and one
// lock_arbiter instance.
//
// Handshake: REQx is level-held by the requester until gntx is seen, and is
// then kept high for as long as the resource is needed. Dropping REQx
// releases the grant on the next rising edge. A tox pulse means the arbiter
// revoked the grant because it was held too long. The requester must then
// drop REQx for at least one edge before it can be granted again.
interface lock_arbiter_if;
    logic REQ1;
    logic REQ2;
    logic gnt1;
    logic gnt2;
    logic to1;
    logic to2;
    logic busy;

    // Requester side (drives requests, observes grants).
    modport master (
        output REQ1,
        output REQ2,
        input  gnt1,
        input  gnt2,
        input  to1,
        input  to2,
        input  busy
    );

    // Arbiter side.
    modport slave (
        input  REQ1,
        input  REQ2,
        output gnt1,
        output gnt2,
        output to1,
        output to2,
        output busy
    );
endinterface

// File: rtl/lock_arbiter.sv
// lock_arbiter: two-requester, single-resource lock arbiter.
//
// - Requester 1 wins contention from IDLE.
// - An active grant is never pre-empted.
// - A grant held for HOLD_MAX cycles is revoked. The holder is then locked out
//   until it drops its request. HOLD_MAX = 0 disables the watchdog.
// - Release to IDLE always costs one cycle before the other side is granted
//   (break-before-make).
//
// Optional build macro LOCK_ARBITER_ROUND_ROBIN_EN: on contention, grant the
// requester not served most recently instead of always requester 1.
//
// Debug outputs: dbg_state is the FSM state (0 idle, 1 grant1, 2 grant2).
// dbg_lock is {lock2, lock1}.
module lock_arbiter #(
    parameter int HOLD_MAX = 17
) (
    input  logic           CLK,
    input  logic           RST,
    lock_arbiter_if.slave  bus,
    output logic [1:0]     dbg_state,
    output logic [1:0]     dbg_lock
);

    // Counter wide enough to hold HOLD_MAX; never narrower than one bit.
    localparam int CW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_HOLD = CW'(HOLD_MAX);
    localparam bit            WD_EN    = (HOLD_MAX != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT1 = 2'd1,
        S_GRANT2 = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          lock1, lock1_nxt;
    logic          lock2, lock2_nxt;
    logic          to1_q, to1_nxt;
    logic          to2_q, to2_nxt;

    logic          req1, req2;
    logic          ereq1, ereq2;
    logic          pick1;
    logic          hold_expired;

    assign req1  = bus.REQ1;
    assign req2  = bus.REQ2;

    // A locked requester is invisible to arbitration until it lets go.
    assign ereq1 = req1 & ~lock1;
    assign ereq2 = req2 & ~lock2;

    // The holder has used its full budget. The revoke happens on the next
    // edge, and only if the holder is still requesting.
    assign hold_expired = WD_EN && (cnt == CNT_HOLD);

`ifdef LOCK_ARBITER_ROUND_ROBIN_EN
    // 1 = requester 2 was served most recently. Reset value is "last
    // served 2", so requester 1 wins the first contention.
    logic last2, last2_nxt;

    assign pick1 = last2;

    // Pointer follows every grant entry out of IDLE.
    always_comb begin
        last2_nxt = last2;
        if (state == S_IDLE && state_nxt == S_GRANT1) last2_nxt = 1'b0;
        if (state == S_IDLE && state_nxt == S_GRANT2) last2_nxt = 1'b1;
    end

    // Pointer register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) last2 <= 1'b1;
        else     last2 <= last2_nxt;
    end
`else
    // Fixed priority: requester 1 always wins contention.
    assign pick1 = 1'b1;
`endif

    // Next-state, hold counter, lockout and timeout-pulse decisions.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        // A lock survives only while its requester keeps REQ high.
        lock1_nxt = lock1 & req1;
        lock2_nxt = lock2 & req2;
        to1_nxt   = 1'b0;
        to2_nxt   = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (ereq1 && (!ereq2 || pick1)) begin
                    state_nxt = S_GRANT1;
                    cnt_nxt   = CNT_ONE;
                end else if (ereq2) begin
                    state_nxt = S_GRANT2;
                    cnt_nxt   = CNT_ONE;
                end
            end

            S_GRANT1: begin
                // Release beats timeout when both land on the same edge.
                if (!req1) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (hold_expired) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    lock1_nxt = 1'b1;
                    to1_nxt   = 1'b1;
                end else if (cnt != CNT_SAT) begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            S_GRANT2: begin
                if (!req2) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (hold_expired) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    lock2_nxt = 1'b1;
                    to2_nxt   = 1'b1;
                end else if (cnt != CNT_SAT) begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter, lockout flags and timeout pulses. Reset clears
    // everything immediately, including the outputs, with no pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            cnt   <= '0;
            lock1 <= 1'b0;
            lock2 <= 1'b0;
            to1_q <= 1'b0;
            to2_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lock1 <= lock1_nxt;
            lock2 <= lock2_nxt;
            to1_q <= to1_nxt;
            to2_q <= to2_nxt;
        end
    end

    // Grants decode directly from the state register, so they are registered
    // and mutually exclusive by construction.
    assign bus.gnt1  = (state == S_GRANT1);
    assign bus.gnt2  = (state == S_GRANT2);
    assign bus.busy  = (state == S_GRANT1) || (state == S_GRANT2);
    assign bus.to1   = to1_q;
    assign bus.to2   = to2_q;

    assign dbg_state = state;
    assign dbg_lock  = {lock2, lock1};

`ifndef SYNTHESIS
    // The two grants must never be high together.
    always_ff @(posedge CLK) begin
        if (!RST) assert (!(bus.gnt1 && bus.gnt2));
    end
`endif

endmodule
